// File: rtl/pipe_mux_pkg.sv
// rtl/pipe_mux_pkg.sv - shared constants, state encoding and clog2 for the pipe_mux family
package pipe_mux_pkg;

    localparam int MAX_NUM_IN = 16;

    // Occupancy encoded as {main_v, skid_v}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    // Never returns less than 1 so a select port always has at least one bit
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_mux_sel.sv
// rtl/pipe_mux_sel.sv - combinational NUM_IN-way select with default-index substitution
module pipe_mux_sel
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_IN      = 6,
    parameter int DEFAULT_IDX = 0,
    localparam int SEL_W      = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic [SEL_W-1:0]        eff_sel
);

    localparam logic [SEL_W:0]   NUM_IN_L  = NUM_IN[SEL_W:0];
    localparam logic [SEL_W-1:0] DEFAULT_L = DEFAULT_IDX[SEL_W-1:0];

    always_comb begin
        eff_sel  = ({1'b0, sel} >= NUM_IN_L) ? DEFAULT_L : sel;
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pipe_mux_skid.sv
// rtl/pipe_mux_skid.sv - registered N-way select with 2-entry skid buffer; PIPE_MUX_SEL_ERR_EN adds sticky sel_err
module pipe_mux_skid
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_IN      = 6,
    parameter int DEFAULT_IDX = 0,
    localparam int SEL_W      = clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef PIPE_MUX_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] new_data, main_data, skid_data;
    logic [SEL_W-1:0] new_sel, main_sel, skid_sel;
    logic             main_v, skid_v;
    logic             accept, xfer;

    pipe_mux_sel #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) u_sel (
        .in_data  (in_data),
        .sel      (sel),
        .sel_data (new_data),
        .eff_sel  (new_sel)
    );

    // in_ready depends only on registered state, so out_ready never reaches it combinationally
    assign accept = in_valid & ~skid_v;
    assign xfer   = main_v & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_sel  <= '0;
            main_v    <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_v    <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            case ({main_v, skid_v})
                ST_EMPTY: begin
                    if (accept) begin
                        main_data <= new_data;
                        main_sel  <= new_sel;
                        main_v    <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        main_data <= new_data;
                        main_sel  <= new_sel;
                    end else if (accept) begin
                        skid_data <= new_data;
                        skid_sel  <= new_sel;
                        skid_v    <= 1'b1;
                    end else if (xfer) begin
                        main_v <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        main_data <= skid_data;
                        main_sel  <= skid_sel;
                        skid_v    <= 1'b0;
                    end
                end
                default: begin
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ~skid_v;
    assign out_data  = main_data;
    assign out_sel   = main_sel;
    assign out_valid = main_v;

`ifdef PIPE_MUX_SEL_ERR_EN
    // Substitution happened exactly when the effective index differs from the raw select
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && (new_sel != sel)) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux_skid.sv
// tb/tb_pipe_mux_skid.sv - scoreboard bench for pipe_mux_skid with directed and random stimulus
module tb_pipe_mux_skid;

    localparam int W   = 32;
    localparam int N   = 6;
    localparam int DEF = 2;
    localparam int SW  = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N*W-1:0]   in_data;
    logic [SW-1:0]    sel;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_sel;
    logic             out_valid;
    logic             out_ready;
`ifdef PIPE_MUX_SEL_ERR_EN
    logic             sel_err;
`endif

    always #5 clock = ~clock;

    pipe_mux_skid #(
        .WIDTH       (W),
        .NUM_IN      (N),
        .DEFAULT_IDX (DEF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PIPE_MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err)
`endif
    );

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } exp_t;

    exp_t q[$];
    bit   err_model;
    int   n_checks;
    int   n_pass;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: effective index is sel when in range, else DEF; data is that input's word
    function automatic exp_t model_pick();
        exp_t e;
        int   idx;
        idx = (int'(sel) < N) ? int'(sel) : DEF;
        e.d = in_data[idx*W +: W];
        e.s = SW'(idx);
        return e;
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        bit   can_accept;
        if (reset) begin
            q.delete();
            err_model = 1'b0;
        end else begin
            can_accept = (q.size() < 2);
            chk("in_ready", 32'(in_ready), 32'(can_accept));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
`ifdef PIPE_MUX_SEL_ERR_EN
            chk("sel_err", 32'(sel_err), 32'(err_model));
`endif
            if (out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_sel", 32'(out_sel), 32'(e.s));
            end
            if (in_valid && can_accept && int'(sel) >= N) begin
                err_model = 1'b1;
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && can_accept) begin
                q.push_back(model_pick());
            end
        end
    end

    task automatic set_pattern();
        for (int k = 0; k < N; k++) begin
            in_data[k*W +: W] = 32'h1000_0000 + 32'(k);
        end
    endtask

    task automatic step(input bit v, input logic [SW-1:0] s, input bit f, input bit r);
        in_valid  = v;
        sel       = s;
        flush     = f;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid  = 1'b0;
        sel       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_pattern();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        step(1, 3'd3, 0, 1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", out_data, 32'h1000_0003);
        chk("lat_sel", 32'(out_sel), 32'd3);
        step(0, 3'd0, 0, 1);

        for (int k = 0; k < N; k++) begin
            step(1, SW'(k), 0, 1);
            chk("stream_ready", 32'(in_ready), 32'd1);
            chk("stream_data", out_data, 32'h1000_0000 + 32'(k));
        end
        step(0, 3'd0, 0, 1);

        step(1, 3'd1, 0, 0);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        step(1, 3'd2, 0, 0);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        step(0, 3'd0, 0, 0);
        chk("bp_hold", 32'(in_ready), 32'd0);
        step(0, 3'd0, 0, 1);
        step(0, 3'd0, 0, 1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        step(1, 3'd7, 0, 1);
        chk("oor_data", out_data, 32'h1000_0002);
        chk("oor_sel", 32'(out_sel), 32'd2);
        step(1, 3'd6, 0, 1);
        chk("oor6_sel", 32'(out_sel), 32'd2);
        step(0, 3'd0, 0, 1);

        step(1, 3'd1, 0, 0);
        step(1, 3'd2, 0, 0);
        step(1, 3'd4, 1, 0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_MUX_SEL_ERR_EN
        chk("flush_keeps_err", 32'(sel_err), 32'd1);
`endif
        step(1, 3'd3, 0, 0);
        step(1, 3'd4, 1, 0);
        chk("flush_one_valid", 32'(out_valid), 32'd0);
        repeat (3) step(0, 3'd0, 0, 1);

        step(1, 3'd1, 0, 0);
        step(1, 3'd2, 0, 0);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_sel", 32'(out_sel), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        step(1, 3'd5, 0, 1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", out_data, 32'h1000_0005);
        chk("post_rst_sel", 32'(out_sel), 32'd5);
`ifdef PIPE_MUX_SEL_ERR_EN
        chk("post_rst_err", 32'(sel_err), 32'd0);
`endif
        step(0, 3'd0, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                in_data[k*W +: W] = $urandom;
            end
            step($urandom_range(0, 9) < 7, SW'($urandom_range(0, 7)),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6);
        end

        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            step(0, 3'd0, 0, 1);
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
